// File: rtl/f100l_pkg.sv
// Shared types and constants for the F100-L instruction fetch stage.
// Holds the fetch FSM encoding, the halt opcode and the long-form field masks.
package f100l_pkg;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_EXT = 2'd1,
        PRESENT   = 2'd2,
        HALTED    = 2'd3
    } fetch_state_t;

    localparam logic [15:0] HALT_OPCODE    = 16'h0400;

    // Long form: non-zero function field with an all-zero address field.
    localparam logic [15:0] LONG_OP_MASK   = 16'hF000;
    localparam logic [15:0] LONG_ADDR_MASK = 16'h07FF;

    function automatic logic is_long_form(input logic [15:0] word);
        return ((word & LONG_OP_MASK) != 16'h0000) &&
               ((word & LONG_ADDR_MASK) == 16'h0000);
    endfunction

endpackage

// File: rtl/inst_length_decode.sv
// Combinational long-form detector for a 16-bit opcode word.
// A long instruction is followed by one extension (address) word.
module inst_length_decode
    import f100l_pkg::*;
(
    input  logic [15:0] i_word,
    output logic        o_long
);

    assign o_long = is_long_form(i_word);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads one or two ROM words into a decoder bundle.
// Optional macro FETCH_HALT_DETECT_EN stops fetching after a HALT is accepted.
module instruction_fetch
    import f100l_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
)(
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [15:0]           rom_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [15:0]           inst_word,
    output logic [15:0]           inst_ext,
    output logic                  inst_long,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halted
);

    fetch_state_t          r_state;
    fetch_state_t          w_next_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [15:0]           r_inst_word;
    logic [15:0]           r_inst_ext;
    logic                  r_inst_long;
    logic [ADDR_WIDTH-1:0] r_inst_pc;
    logic                  w_long;
    logic                  w_halt_hit;
    logic                  w_valid;
    logic                  w_halted;

    inst_length_decode u_len (
        .i_word (rom_data),
        .o_long (w_long)
    );

`ifdef FETCH_HALT_DETECT_EN
    assign w_halt_hit = (r_inst_word == HALT_OPCODE);
`else
    assign w_halt_hit = 1'b0;
`endif

    // State register; reset abandons any fetch in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH_OP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; a redirect overrides every state.
    always_comb begin
        w_next_state = r_state;
        if (redirect_valid) begin
            w_next_state = FETCH_OP;
        end else begin
            unique case (r_state)
                FETCH_OP: begin
                    w_next_state = w_long ? FETCH_EXT : PRESENT;
                end
                FETCH_EXT: begin
                    w_next_state = PRESENT;
                end
                PRESENT: begin
                    if (inst_ready) begin
                        w_next_state = w_halt_hit ? HALTED
                                                  : FETCH_OP;
                    end
                end
                HALTED: begin
                    w_next_state = HALTED;
                end
                default: begin
                    w_next_state = FETCH_OP;
                end
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        w_valid  = 1'b0;
        w_halted = 1'b0;
        if (r_state == PRESENT) begin
            w_valid = 1'b1;
        end
`ifdef FETCH_HALT_DETECT_EN
        if (r_state == HALTED) begin
            w_halted = 1'b1;
        end
`endif
    end

    // PC and bundle capture; bundle is frozen outside the fetch states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_inst_word <= '0;
            r_inst_ext  <= '0;
            r_inst_long <= 1'b0;
            r_inst_pc   <= '0;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else begin
            case (r_state)
                FETCH_OP: begin
                    r_inst_word <= rom_data;
                    r_inst_pc   <= r_pc;
                    r_inst_long <= w_long;
                    r_pc        <= r_pc + 1'b1;
                    if (!w_long) begin
                        r_inst_ext <= '0;
                    end
                end
                FETCH_EXT: begin
                    r_inst_ext <= rom_data;
                    r_pc       <= r_pc + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_address = r_pc;
    assign inst_valid  = w_valid;
    assign halted      = w_halted;
    assign inst_word   = r_inst_word;
    assign inst_ext    = r_inst_ext;
    assign inst_long   = r_inst_long;
    assign inst_pc     = r_inst_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: transaction-level model plus directed scenarios.
// Define FETCH_HALT_DETECT_EN for both bench and RTL to cover the halt path.
module tb_instruction_fetch;

    localparam int AW   = 10;
    localparam int SIZE = 1 << AW;
    localparam int RPC  = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] rom_address;
    logic [15:0]   rom_data;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [15:0]   inst_word;
    logic [15:0]   inst_ext;
    logic          inst_long;
    logic [AW-1:0] inst_pc;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halted;

    logic [15:0] rom [0:SIZE-1];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: start address of current instruction and edges since its fetch began.
    int m_pc     = RPC;
    int m_age    = 0;
    bit m_halted = 1'b0;

    instruction_fetch #(
        .ADDR_WIDTH (AW),
        .RESET_PC   (AW'(RPC))
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_address    (rom_address),
        .rom_data       (rom_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_word      (inst_word),
        .inst_ext       (inst_ext),
        .inst_long      (inst_long),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    assign rom_data = rom[rom_address];

    always #5 clk = ~clk;

    function automatic int wlen(input int pc);
        logic [15:0] w;
        w = rom[pc % SIZE];
        if ((w >> 12) != 0 && (w % 2048) == 0) return 2;
        return 1;
    endfunction

    function automatic bit m_valid();
        return !m_halted && m_age >= wlen(m_pc);
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_on();
        reset = 1'b1;
        redirect_valid = 1'b0;
        cyc();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < SIZE; i++) rom[i] = 16'h0000;
    endtask

    task automatic load_basic();
        clear_rom();
        rom[0] = 16'h8000;
        rom[1] = 16'h0019;
        rom[2] = 16'h0400;
    endtask

    // Model update at each active edge.
    always @(posedge clk) begin
        if (reset) begin
            m_pc     <= RPC;
            m_age    <= 0;
            m_halted <= 1'b0;
        end else if (redirect_valid) begin
            m_pc     <= int'(redirect_pc);
            m_age    <= 0;
            m_halted <= 1'b0;
        end else if (m_halted) begin
            m_age <= 0;
        end else if (m_valid() && inst_ready) begin
            m_pc  <= (m_pc + wlen(m_pc)) % SIZE;
            m_age <= 0;
`ifdef FETCH_HALT_DETECT_EN
            if (rom[m_pc] == 16'h0400) m_halted <= 1'b1;
`endif
        end else if (m_age < 3) begin
            m_age <= m_age + 1;
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_valid", inst_valid, 0);
            chk("rst_word", inst_word, 0);
            chk("rst_ext", inst_ext, 0);
            chk("rst_long", inst_long, 0);
            chk("rst_pc", inst_pc, 0);
            chk("rst_halted", halted, 0);
            chk("rst_addr", rom_address, RPC);
        end else begin
            chk("m_valid", inst_valid, m_valid());
            chk("m_halted", halted, m_halted);
            if (m_valid()) begin
                chk("m_word", inst_word, rom[m_pc]);
                chk("m_long", inst_long, wlen(m_pc) == 2);
                chk("m_ext", inst_ext, (wlen(m_pc) == 2)
                    ? rom[(m_pc + 1) % SIZE] : 16'h0);
                chk("m_ipc", inst_pc, m_pc);
                chk("m_addr", rom_address,
                    (m_pc + wlen(m_pc)) % SIZE);
            end else if (m_halted) begin
                chk("m_addr_h", rom_address, m_pc);
            end else begin
                chk("m_addr_f", rom_address,
                    (m_pc + m_age) % SIZE);
            end
        end
    end

    initial begin
        logic [15:0] tbl [0:15];
        tbl = '{16'h8000, 16'h0019, 16'h0800, 16'h1800,
                16'h0000, 16'hF000, 16'h00AB, 16'hF001,
                16'h2000, 16'h3333, 16'h0001, 16'hA800,
                16'h4444, 16'h5000, 16'h0007, 16'hFFFF};

        // Basic long + short sequence with the decoder always ready.
        load_basic();
        cyc();
        inst_ready = 1'b1;
        rst_on();
        reset = 1'b0;
        cyc();
        chk("s1_not_yet", inst_valid, 0);
        cyc();
        chk("s1_valid", inst_valid, 1);
        chk("s1_word", inst_word, 16'h8000);
        chk("s1_ext", inst_ext, 16'h0019);
        chk("s1_long", inst_long, 1);
        chk("s1_pc", inst_pc, 0);
        cyc();
        cyc();
        chk("s1b_valid", inst_valid, 1);
        chk("s1b_word", inst_word, 16'h0400);
        chk("s1b_long", inst_long, 0);
        chk("s1b_ext", inst_ext, 0);
        chk("s1b_pc", inst_pc, 2);
`ifdef FETCH_HALT_DETECT_EN
        begin
            int k;
            k = 0;
            while (!halted && k < 20) begin
                cyc();
                k++;
            end
        end
        chk("halt_reached", halted, 1);
        for (int i = 0; i < 10; i++) begin
            chk("halt_addr", rom_address, 3);
            chk("halt_valid", inst_valid, 0);
            cyc();
        end
        inst_ready = 1'b0;
        redirect_pc = '0;
        redirect_valid = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        chk("unhalt", halted, 0);
        cyc();
        cyc();
        chk("rehalt_valid", inst_valid, 1);
        chk("rehalt_word", inst_word, 16'h8000);
        chk("rehalt_pc", inst_pc, 0);
`else
        cyc();
        cyc();
        chk("nohalt_valid", inst_valid, 1);
        chk("nohalt_pc", inst_pc, 3);
        chk("nohalt_flag", halted, 0);
`endif

        // Back-pressure: bundle and pc frozen while not ready.
        inst_ready = 1'b0;
        rst_on();
        load_basic();
        reset = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", inst_valid, 1);
            chk("bp_word", inst_word, 16'h8000);
            chk("bp_ext", inst_ext, 16'h0019);
            chk("bp_ipc", inst_pc, 0);
            chk("bp_addr", rom_address, 2);
            cyc();
        end

        // Redirect during the extension fetch drops the partial bundle.
        inst_ready = 1'b1;
        rst_on();
        load_basic();
        rom[10'h100] = 16'h1234;
        reset = 1'b0;
        cyc();
        redirect_pc = 10'h100;
        redirect_valid = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        chk("rd_drop", inst_valid, 0);
        chk("rd_addr", rom_address, 10'h100);
        cyc();
        chk("rd_valid", inst_valid, 1);
        chk("rd_ipc", inst_pc, 10'h100);
        chk("rd_word", inst_word, 16'h1234);
        chk("rd_long", inst_long, 0);

        // Long op at the top address takes its extension from address 0.
        inst_ready = 1'b0;
        rst_on();
        clear_rom();
        rom[10'h3FF] = 16'h8000;
        rom[0] = 16'h1234;
        reset = 1'b0;
        redirect_pc = 10'h3FF;
        redirect_valid = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        cyc();
        chk("wr_valid", inst_valid, 1);
        chk("wr_ipc", inst_pc, 10'h3FF);
        chk("wr_ext", inst_ext, 16'h1234);
        chk("wr_long", inst_long, 1);
        chk("wr_addr", rom_address, 1);

        // Reset in PRESENT drops valid at once and restarts from RESET_PC.
        rst_on();
        load_basic();
        reset = 1'b0;
        cyc();
        cyc();
        chk("ar_pre", inst_valid, 1);
        reset = 1'b1;
        #1;
        chk("ar_async", inst_valid, 0);
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        chk("ar_valid", inst_valid, 1);
        chk("ar_ipc", inst_pc, RPC);
        chk("ar_word", inst_word, 16'h8000);

        // Mixed stream with toggling ready and redirects.
        rst_on();
        clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = tbl[i];
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            inst_ready = (i % 3) != 1;
            redirect_valid = (i == 30) || (i == 45);
            redirect_pc = (i == 30) ? 10'd5 : 10'd15;
            cyc();
        end
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        repeat (5) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, program ROM word-address width.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rom_address  output  ADDR_WIDTH  word address to combinational program ROM.
REQ-006 rom_data  input  16  ROM word for rom_address, valid in the same cycle.
REQ-007 inst_valid  output  1  instruction bundle available to decoder.
REQ-008 inst_ready  input  1  decoder accepts bundle when high with inst_valid.
REQ-009 inst_word  output  16  opcode word.
REQ-010 inst_ext  output  16  extension (address) word; 0 for single-word instructions.
REQ-011 inst_long  output  1  bundle is a two-word instruction.
REQ-012 inst_pc  output  ADDR_WIDTH  address of inst_word.
REQ-013 redirect_valid  input  1  load new PC (jump/branch/interrupt).
REQ-014 redirect_pc  input  ADDR_WIDTH  new PC.
REQ-015 halted  output  1  fetch stopped on halt (see Configuration).

Function
REQ-016 States SHALL be FETCH_OP, FETCH_EXT, PRESENT, HALTED.
REQ-017 rom_address SHALL equal the registered pc in every state.
REQ-018 FETCH_OP: capture rom_data into inst_word, pc into inst_pc, pc <= pc+1; go FETCH_EXT if long, else clear inst_ext and go PRESENT.
REQ-019 Long rule: word is long when bits[15:12] != 4'h0 and bits[10:0] == 0.
REQ-020 FETCH_EXT: capture rom_data into inst_ext, pc <= pc+1, go PRESENT.
REQ-021 PRESENT: inst_valid=1, outputs held stable; on inst_ready go FETCH_OP.
REQ-022 inst_valid SHALL be 0 in all states other than PRESENT.
REQ-023 Latency: short instruction valid 1 cycle after FETCH_OP entry, long after 2.
REQ-024 pc SHALL wrap modulo 2^ADDR_WIDTH; long op at last address takes ext from address 0.
REQ-025 redirect_valid SHALL have priority in every state: pc <= redirect_pc, state <= FETCH_OP, any partial fetch discarded.
REQ-026 redirect_valid with inst_valid & inst_ready in same cycle: handshake counts as accepted; redirect sets pc.
REQ-027 inst_ready while inst_valid=0 SHALL be ignored.

Reset
REQ-028 While reset high: pc=RESET_PC, state=FETCH_OP, inst_valid=0, inst_word=0, inst_ext=0, inst_long=0, inst_pc=0, halted=0.
REQ-029 Reset asserted mid-fetch SHALL abandon the instruction; first fetch after release is from RESET_PC.

Configuration
REQ-030 Macro FETCH_HALT_DETECT_EN: when defined, accepting a bundle with inst_word == 16'h0400 SHALL enter HALTED (halted=1, no ROM fetch progress, pc held) until redirect_valid, which clears halted and goes FETCH_OP.
REQ-031 Without FETCH_HALT_DETECT_EN: HALTED unreachable, halted tied 0, 16'h0400 treated as an ordinary short instruction.

Structure
REQ-032 State enumeration, HALT_OPCODE (16'h0400) and long-form field masks SHALL live in shared package f100l_pkg.
REQ-033 Long-form detection SHALL be a sub-module inst_length_decode (16-bit word in, long flag out, combinational); no other sub-modules.

Verification
REQ-034 ROM 0:8000,1:0019,2:0400, inst_ready=1: first bundle inst_word=8000, inst_ext=0019, inst_long=1, inst_pc=0, inst_valid 2 cycles after reset release; next bundle 0400, long=0, pc=2.
REQ-035 Same ROM, FETCH_HALT_DETECT_EN defined: after 0400 accepted halted=1, rom_address stays 3 for 10 cycles; redirect_pc=0 -> halted=0, bundle 8000 re-presented.
REQ-036 inst_ready=0 for 5 cycles in PRESENT: inst_valid stays 1, all bundle outputs unchanged, pc unchanged.
REQ-037 redirect_valid pulse with redirect_pc=0x100 during FETCH_EXT: partial bundle dropped, next bundle inst_pc=0x100.
REQ-038 Long op 8000 at address 0x3FF, ext 0x1234 at 0: bundle inst_ext=1234, next fetch address 1.
REQ-039 reset asserted during PRESENT: inst_valid falls asynchronously, restart fetch at RESET_PC.
